bit_serial_alu_seq: RTL
=======================

Name: bit_serial_alu_seq

Overview:
Multi-bit ALU sequencer that drives an operation one bit per clock, LSB first. It uses the same op encoding and per-bit semantics as the team's 1-bit URG ALU slice. The block owns the carry chain: a carry flop links successive bit operations, which the single-bit slice cannot do by itself. It sits between the control logic issuing WIDTH-bit operations and the bit-level datapath, and returns a WIDTH-bit result with flags.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE or DONE
op  input  2  {alucon, alucon0}: 00 add, 01 sub (A + ~B + 1), 10 AND, 11 OR
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  operation result, held until next accepted start
carry  output  1  carry out of MSB (add/sub); 0 for AND/OR
zero  output  1  result == 0
neg  output  1  result[WIDTH-1] (the slice's N)
ovf  output  1  signed overflow (add/sub); 0 for AND/OR

Behaviour:
- Reset: state IDLE. busy, done, result, carry, zero, neg and ovf are all 0. Bit counter = 0, carry flop = 0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start=1 at edge k while in IDLE or DONE is accepted.
  - On acceptance: capture a, b, op into shift/hold registers; clear result. Carry flop loads op[0] (0 for add, 1 for sub; either value for logic ops, since it is masked). Counter = 0. Go to RUN.
  - start while in RUN is ignored: no capture, no restart.
- RUN, one bit i per edge, i = 0..WIDTH-1:
  - bb = op[0] ? ~b[i] : b[i]
  - sum = a[i] ^ bb ^ c
  - cout = maj(a[i], bb, c)
  - Bit result r = sum for op 00/01; a[i] & b[i] for 10; a[i] | b[i] for 11.
  - r is written into result[i]; the carry flop takes cout.
  - When i = WIDTH-1, also record cin_msb = c (carry into the MSB) before the update.
- Latency: edges k+1 .. k+WIDTH process bits 0..WIDTH-1, and busy=1 for those WIDTH cycles. After edge k+WIDTH, state = DONE, done=1, busy=0. Total: WIDTH+1 edges from start to done.
- Flags are registered on the final RUN edge and become valid in the DONE cycle:
  - carry = final cout & ~op[1] (the slice's alucon mask). For sub, carry=1 means no borrow.
  - ovf = (cout ^ cin_msb) & ~op[1]
  - zero = (final result == 0)
  - neg = final result MSB
- DONE lasts exactly one cycle. The next edge goes to IDLE, or to RUN if start=1 (back-to-back operations, no idle gap).
- Flags and result hold their values through IDLE until the next accepted start. On acceptance, result, carry, ovf and neg are cleared and zero is set to 1. done is low except in DONE.
- Reset mid-operation: rst=1 at any edge aborts to the reset state. No done pulse; partial result is discarded (reads 0).
- rst and start in the same cycle: rst wins.
- op, a and b changing during RUN have no effect.

Test Plan:
- WIDTH=8, add, a=0x5A, b=0x3C -> done at 9th edge after start; result=0x96, carry=0, ovf=1, neg=1, zero=0.
- Add, a=0xFF, b=0x01 -> result=0x00, carry=1, zero=1, ovf=0, neg=0.
- Sub, a=0x01, b=0x02 -> result=0xFF, carry=0 (borrow), neg=1, ovf=0. Then sub, a=0x10, b=0x10 -> result=0x00, carry=1, zero=1.
- AND a=0xF0, b=0x3C -> 0x30, carry=0, ovf=0. Then OR a=0xF0, b=0x0F -> 0xFF, neg=1, carry=0. Issue the second start during the DONE cycle of the first: no gap, and a single done pulse per op.
- Start pulses at cycles 3 and 6 of a running add, with different a/b: both ignored; original result delivered on schedule, and busy stays high for exactly 8 cycles.
- rst asserted at bit 4 of an add: next cycle busy=0, done=0, result=0, all flags 0. No done pulse ever follows. A new start afterwards completes normally.

Source files
------------

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit add/sub/AND/OR one bit per clock,
// LSB first, owning the carry chain between bit slices and reporting flags.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [1:0]       opq;
  logic [CW-1:0]    cnt;
  logic             c;

  logic             bb, sum, cout, r, last;
  logic [WIDTH-1:0] res_next;

  // Single-bit slice: operands are shifted so bit i always sits at position 0.
  always_comb begin
    bb   = opq[0] ? ~sb[0] : sb[0];
    sum  = sa[0] ^ bb ^ c;
    cout = (sa[0] & bb) | (sa[0] & c) | (bb & c);
    case (opq)
      2'b10:   r = sa[0] & sb[0];
      2'b11:   r = sa[0] | sb[0];
      default: r = sum;
    endcase
    res_next      = result;
    res_next[cnt] = r;
    last          = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      opq    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            opq    <= op;
            c      <= op[0];
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            neg    <= 1'b0;
            zero   <= 1'b1;
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          result <= res_next;
          c      <= cout;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            // c still holds the carry into the MSB here, giving signed overflow.
            carry <= cout & ~opq[1];
            ovf   <= (cout ^ c) & ~opq[1];
            zero  <= (res_next == '0);
            neg   <= res_next[WIDTH-1];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
